// File: rtl/zx_video_pkg.sv
// Shared ZX Spectrum screen constants and the line-fetch state encoding.
package zx_video_pkg;

  localparam logic [12:0] ATTR_BASE    = 13'h1800;
  localparam int          SCREEN_COLS  = 32;
  localparam int          SCREEN_LINES = 192;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PIX_ISSUE,
    ST_PIX_WAIT,
    ST_ATTR_ISSUE,
    ST_ATTR_WAIT,
    ST_LAST
  } fetch_state_e;

endpackage

// File: rtl/zx_scr_addr.sv
// Spectrum screen address map: (line, column, bitmap/attribute) -> 13-bit screen RAM address.
module zx_scr_addr
  import zx_video_pkg::*;
(
  input  logic [7:0]  line_i,
  input  logic [4:0]  col_i,
  input  logic        is_attr_i,
  output logic [12:0] addr_o
);

  // Bitmap rows are interleaved: third, pixel row within cell, cell row, column.
  always_comb begin
    if (is_attr_i) addr_o = ATTR_BASE + {3'b000, line_i[7:3], col_i};
    else           addr_o = {line_i[7:6], line_i[2:0], line_i[5:3], col_i};
  end

endmodule

// File: rtl/zx_line_fetch.sv
// Read-only screen RAM initiator: fetches one scanline as 32 {bitmap, attribute} pairs.
// Optional ZX_FLASH_EN adds flash_phase input for attribute-driven bitmap inversion.
module zx_line_fetch
  import zx_video_pkg::*;
#(
  parameter int unsigned RD_LAT    = 2,
  parameter int unsigned LAST_LINE = SCREEN_LINES - 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  line,
  input  logic        grant,
`ifdef ZX_FLASH_EN
  input  logic        flash_phase,
`endif
  output logic        busy,
  output logic        done,
  output logic [12:0] ad,
  output logic        ce,
  output logic        oce,
  output logic        wre,
  output logic        iorq,
  input  logic [7:0]  data_in,
  output logic        pix_valid,
  output logic [7:0]  pix_data,
  output logic [7:0]  attr_data,
  output logic [4:0]  col
);

  localparam int unsigned       WAIT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_LAT - 1);
  localparam logic [4:0]        LAST_COL  = 5'(SCREEN_COLS - 1);

  fetch_state_e      state_q,    state_d;
  logic [7:0]        line_q,     line_d;
  logic [4:0]        col_cnt_q,  col_cnt_d;
  logic [WAIT_W-1:0] wait_q,     wait_d;
  logic [7:0]        pix_byte_q, pix_byte_d;
  logic              pv_q,       pv_d;
  logic [7:0]        pix_out_q,  pix_out_d;
  logic [7:0]        attr_out_q, attr_out_d;
  logic [4:0]        col_out_q,  col_out_d;

  logic        is_attr;
  logic [12:0] scr_addr;

  assign is_attr = (state_q == ST_ATTR_ISSUE);

  zx_scr_addr u_scr_addr (
    .line_i    (line_q),
    .col_i     (col_cnt_q),
    .is_attr_i (is_attr),
    .addr_o    (scr_addr)
  );

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    line_d     = line_q;
    col_cnt_d  = col_cnt_q;
    wait_d     = wait_q;
    pix_byte_d = pix_byte_q;
    pv_d       = 1'b0;
    pix_out_d  = pix_out_q;
    attr_out_d = attr_out_q;
    col_out_d  = col_out_q;
    ad         = '0;
    ce         = 1'b0;
    oce        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start && (line <= 8'(LAST_LINE))) begin
          line_d    = line;
          col_cnt_d = '0;
          state_d   = ST_PIX_ISSUE;
        end
      end
      ST_PIX_ISSUE, ST_ATTR_ISSUE: begin
        ad = scr_addr;
        if (grant) begin
          ce      = 1'b1;
          oce     = 1'b1;
          wait_d  = '0;
          state_d = (state_q == ST_PIX_ISSUE) ? ST_PIX_WAIT : ST_ATTR_WAIT;
        end
      end
      ST_PIX_WAIT: begin
        oce = 1'b1;
        if (wait_q == WAIT_LAST) begin
          pix_byte_d = data_in;
          state_d    = ST_ATTR_ISSUE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_ATTR_WAIT: begin
        oce = 1'b1;
        if (wait_q == WAIT_LAST) begin
          pv_d       = 1'b1;
          pix_out_d  = pix_byte_q;
          attr_out_d = data_in;
          col_out_d  = col_cnt_q;
          // The final column parks in LAST so no 33rd read can be issued.
          if (col_cnt_q == LAST_COL) begin
            state_d = ST_LAST;
          end else begin
            col_cnt_d = col_cnt_q + 5'd1;
            state_d   = ST_PIX_ISSUE;
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_LAST: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      line_q     <= '0;
      col_cnt_q  <= '0;
      wait_q     <= '0;
      pix_byte_q <= '0;
      pv_q       <= 1'b0;
      pix_out_q  <= '0;
      attr_out_q <= '0;
      col_out_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state_q    <= state_d;
      line_q     <= line_d;
      col_cnt_q  <= col_cnt_d;
      wait_q     <= wait_d;
      pix_byte_q <= pix_byte_d;
      pv_q       <= pv_d;
      pix_out_q  <= pix_out_d;
      attr_out_q <= attr_out_d;
      col_out_q  <= col_out_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_LAST);
  assign wre       = 1'b0;
  assign iorq      = 1'b0;
  assign pix_valid = pv_q;
  assign attr_data = attr_out_q;
  assign col       = col_out_q;

`ifdef ZX_FLASH_EN
  assign pix_data = pix_out_q ^ {8{pv_q & attr_out_q[7] & flash_phase}};
`else
  assign pix_data = pix_out_q;
`endif

endmodule

// File: tb/tb_zx_line_fetch.sv
// Scoreboard bench for zx_line_fetch: RAM model with RD_LAT latency, address and pair queues.
module tb_zx_line_fetch;

  localparam int RD_LAT   = 2;
  localparam int PAIR_CYC = 2 * (RD_LAT + 1);

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  line = '0;
  logic        grant = 1'b1;
  logic        busy, done, ce, oce, wre, iorq, pix_valid;
  logic [12:0] ad;
  logic [7:0]  data_in, pix_data, attr_data;
  logic [4:0]  col;
`ifdef ZX_FLASH_EN
  logic        flash_phase = 1'b0;
`endif

  always #5 clk = ~clk;

  zx_line_fetch #(.RD_LAT(RD_LAT)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .line      (line),
    .grant     (grant),
`ifdef ZX_FLASH_EN
    .flash_phase (flash_phase),
`endif
    .busy      (busy),
    .done      (done),
    .ad        (ad),
    .ce        (ce),
    .oce       (oce),
    .wre       (wre),
    .iorq      (iorq),
    .data_in   (data_in),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .attr_data (attr_data),
    .col       (col)
  );

  typedef struct {
    logic [4:0] col;
    logic [7:0] pix;
    logic [7:0] attr;
  } pair_t;

  logic [12:0] addr_exp_q[$];
  pair_t       pair_exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  mem [8192];
  logic [7:0]  rd_pipe [RD_LAT];
  int          pcyc = 0;
  int          start_pcyc = 0;
  int          last_pv_pcyc = 0;
  bit          first_pv_pending = 1'b0;
  bit          sb_en = 1'b0;
  int          grant_mode = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] ram_init(input int a);
    return 8'((a * 7) ^ (a >> 8) ^ 'h5A);
  endfunction

  function automatic logic [12:0] pix_addr(input int l, input int c);
    return 13'(((l & 'hC0) << 5) | ((l & 7) << 8) | ((l & 'h38) << 2) | c);
  endfunction

  function automatic logic [12:0] attr_addr(input int l, input int c);
    return 13'('h1800 + (l >> 3) * 32 + c);
  endfunction

  // RAM model: address sampled on ce, data appears RD_LAT cycles after presentation.
  always @(posedge clk) begin
    rd_pipe[0] <= ce ? mem[ad] : 8'hEE;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign data_in = rd_pipe[RD_LAT-1];

  always @(posedge clk) pcyc <= pcyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      grant = (grant_mode == 1) ? (pcyc % 3 == 0) : 1'b1;
    end
  end

  // Monitor: reads against the address queue, output pairs against the pair queue.
  always @(negedge clk) begin
    if (sb_en) begin
      if (ce) begin
        check("ce_needs_grant", 64'(grant), 64'd1);
        check("wre_iorq", 64'({wre, iorq}), 64'd0);
        check("read_expected", 64'(addr_exp_q.size() != 0), 64'd1);
        if (addr_exp_q.size() != 0) check("ad", 64'(ad), 64'(addr_exp_q.pop_front()));
      end
      if (pix_valid) begin
        check("pv_expected", 64'(pair_exp_q.size() != 0), 64'd1);
        if (pair_exp_q.size() != 0) begin
          pair_t e;
          e = pair_exp_q.pop_front();
          check("col", 64'(col), 64'(e.col));
          check("pix_data", 64'(pix_data), 64'(e.pix));
          check("attr_data", 64'(attr_data), 64'(e.attr));
          check("done_with_last", 64'(done), 64'(e.col == 5'd31));
        end
        if (first_pv_pending) check("first_latency", 64'(pcyc - start_pcyc), 64'(PAIR_CYC + 1));
        else if (grant_mode == 0) check("pair_spacing", 64'(pcyc - last_pv_pcyc), 64'(PAIR_CYC));
        first_pv_pending = 1'b0;
        last_pv_pcyc = pcyc;
      end else if (done) begin
        check("done_without_pv", 64'(done), 64'd0);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check(tag, 64'({busy, done, ad, ce, oce, wre, iorq, pix_valid, pix_data, attr_data, col}), 64'd0);
  endtask

  task automatic fetch_line(input int l);
    for (int c = 0; c < 32; c++) begin
      pair_t p;
      addr_exp_q.push_back(pix_addr(l, c));
      addr_exp_q.push_back(attr_addr(l, c));
      p.col  = 5'(c);
      p.pix  = mem[pix_addr(l, c)];
      p.attr = mem[attr_addr(l, c)];
`ifdef ZX_FLASH_EN
      if (flash_phase && p.attr[7]) p.pix = ~p.pix;
`endif
      pair_exp_q.push_back(p);
    end
    @(negedge clk);
    start = 1'b1;
    line = 8'(l);
    start_pcyc = pcyc;
    first_pv_pending = (grant_mode == 0);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    @(negedge clk);
    check({tag, "_busy_drop"}, 64'(busy), 64'd0);
    check({tag, "_reads_left"}, 64'(addr_exp_q.size()), 64'd0);
    check({tag, "_pairs_left"}, 64'(pair_exp_q.size()), 64'd0);
    addr_exp_q.delete();
    pair_exp_q.delete();
  endtask

  task automatic try_bad_start(input logic [7:0] l);
    bit any_act = 1'b0;
    @(negedge clk);
    start = 1'b1;
    line = l;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      any_act |= (busy | ce | done);
      @(negedge clk);
    end
    check("bad_line_ignored", 64'(any_act), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 8192; a++) mem[a] = ram_init(a);
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_values");
    reset_n = 1'b1;
    sb_en = 1'b1;

    fetch_line(0);   wait_done("line0", 400);
    fetch_line(1);   wait_done("line1", 400);
    fetch_line(8);   wait_done("line8", 400);
    fetch_line(191); wait_done("line191", 400);

    grant_mode = 1;
    fetch_line(100); wait_done("grant_toggle", 1200);
    grant_mode = 0;
    repeat (2) @(negedge clk);

    try_bad_start(8'd192);
    try_bad_start(8'd255);

    // A start pulse mid-fetch must leave the running line untouched.
    fetch_line(64);
    repeat (20) @(negedge clk);
    start = 1'b1;
    line = 8'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done("start_while_busy", 400);

    begin
      bit found = 1'b0;
      fetch_line(50);
      for (int i = 0; i < 400; i++) begin
        @(negedge clk);
        if (pix_valid && col == 5'd10) begin
          found = 1'b1;
          break;
        end
      end
      check("reached_col10", 64'(found), 64'd1);
      #2;
      sb_en = 1'b0;
      reset_n = 1'b0;
      #1;
      check_reset_outputs("reset_mid_fetch");
      addr_exp_q.delete();
      pair_exp_q.delete();
      repeat (2) @(negedge clk);
      check_reset_outputs("reset_held");
      reset_n = 1'b1;
      sb_en = 1'b1;
      fetch_line(5);
      wait_done("after_reset", 400);
    end

`ifdef ZX_FLASH_EN
    mem[0]        = 8'h3C;
    mem[13'h1800] = 8'h87;
    flash_phase = 1'b1;
    fetch_line(0); wait_done("flash_on", 400);
    flash_phase = 1'b0;
    fetch_line(0); wait_done("flash_off", 400);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
